serial_multiplier: RTL and testbench

Shift-and-add serial multiplier for the GF(2^255-19) datapath. It takes two 255-bit operands and produces the full 510-bit product, zero-extended to 512 bits, at one operand bit per cycle. The product feeds the 512-bit input of the downstream serial modular reducer. The two blocks together form the field multiply used by the curve arithmetic.

---
 rtl/curve25519_pkg.sv | 19 +
 rtl/serial_multiplier.sv | 91 +++++++++
 tb/tb_serial_multiplier.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/curve25519_pkg.sv
// Shared widths, field prime and FSM state encoding for the
// GF(2^255-19) serial multiplier and the serial modular reducer.
package curve25519_pkg;

    localparam int WIDE_OP  = 255;
    localparam int WIDE_MOD = 255;
    localparam int WIDE_IN  = 512;
    localparam int WIDE_OUT = 512;

    // 2^255-19: all ones except the low byte, which is 0xED
    localparam logic [WIDE_MOD-1:0] PRIME = {{(WIDE_MOD-5){1'b1}}, 5'b01101};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT     = 2'd1,
        FINALIZE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_multiplier.sv
// Shift-and-add multiplier: WIDE_OP x WIDE_OP -> WIDE_OUT, one B bit per cycle.
// Define EARLY_EXIT_EN to stop once no set bits remain in B (data-dependent time).
module serial_multiplier #(
    parameter int WIDE_OP  = curve25519_pkg::WIDE_OP,
    parameter int WIDE_OUT = curve25519_pkg::WIDE_OUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDE_OP-1:0]  A,
    input  logic [WIDE_OP-1:0]  B,
    output logic [WIDE_OUT-1:0] product,
    output logic                done,
    output logic                busy
);
    import curve25519_pkg::*;

    localparam int CNT_W = $clog2(WIDE_OP) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDE_OP - 1);

    state_t              state;
    state_t              state_nx;
    logic [WIDE_OUT-1:0] a_sh;
    logic [WIDE_OUT-1:0] acc;
    logic [WIDE_OP-1:0]  b_sh;
    logic [CNT_W-1:0]    count;
    logic                last_step;

`ifdef EARLY_EXIT_EN
    // B bits above the one consumed this cycle are all clear
    assign last_step = (count == LAST_CNT) || (b_sh[WIDE_OP-1:1] == '0);
`else
    assign last_step = (count == LAST_CNT);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (start) state_nx = MULT;
            MULT:     if (last_step) state_nx = FINALIZE;
            FINALIZE: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= WIDE_OUT'(A);
                        b_sh  <= B;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                MULT: begin
                    if (b_sh[0]) acc <= acc + a_sh;
                    a_sh  <= a_sh << 1;
                    b_sh  <= b_sh >> 1;
                    count <= count + CNT_W'(1);
                end
                FINALIZE: begin
                    product <= acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_multiplier.sv
// Directed bench for serial_multiplier: countdown/arithmetic model checked
// every cycle, plus literal expectations on latency and products.
module tb_serial_multiplier;
    import curve25519_pkg::*;

    localparam int WP = 255;
    localparam int WO = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [WP-1:0] A = '0;
    logic [WP-1:0] B = '0;
    logic [WO-1:0] product;
    logic          done;
    logic          busy;

    int total = 0;
    int bad   = 0;

    serial_multiplier dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .A       (A),
        .B       (B),
        .product (product),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WO-1:0] act,
                       input logic [WO-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Edges after the accepting edge until done is raised
    function automatic int done_edge(input logic [WP-1:0] b);
        int msb;
        msb = 0;
        for (int i = 0; i < WP; i++) if (b[i]) msb = i;
`ifdef EARLY_EXIT_EN
        return msb + 2;
`else
        return WP + 1;
`endif
    endfunction

    // Model: idle when m_left==0, otherwise edges remaining until done
    int            m_left = 0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [WO-1:0] m_prod = '0;
    logic [WO-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_prod = '0;
        end else if (m_left == 0) begin
            m_done = 1'b0;
            if (start) begin
                m_pend = WO'(A) * WO'(B);
                m_left = done_edge(B);
                m_busy = 1'b1;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_busy = 1'b0;
                m_prod = m_pend;
            end
        end
    end

    always @(negedge clk) begin
        chk("done", WO'(done), WO'(m_done));
        chk("busy", WO'(busy), WO'(m_busy));
        chk("product", product, m_prod);
    end

    // Called at a negedge; returns at the negedge where done is seen
    task automatic run_op(input string name, input logic [WP-1:0] a,
                          input logic [WP-1:0] b, input int exp_edge,
                          input logic [WO-1:0] exp_prod);
        int n;
        int bc;
        start = 1'b1;
        A = a;
        B = b;
        @(negedge clk);
        start = 1'b0;
        A = '0;
        B = '0;
        n = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end
        chk({name, "_lat"}, WO'(n), WO'(exp_edge));
        chk({name, "_busy_cycles"}, WO'(bc), WO'(exp_edge));
        chk({name, "_prod"}, product, exp_prod);
    endtask

    logic [WO-1:0] max_sq;
    logic [WP-1:0] ones;
    logic [WP-1:0] p254;
    int            n;

    initial begin
        ones   = '1;
        p254   = '0;
        p254[254] = 1'b1;
        max_sq = (WO'(1) << 510) - (WO'(1) << 256) + WO'(1);

        @(negedge clk);
        chk("rst_done", WO'(done), '0);
        chk("rst_busy", WO'(busy), '0);
        chk("rst_prod", product, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

`ifdef EARLY_EXIT_EN
        run_op("t1", WP'(3), WP'(5), 4, WO'(15));
`else
        run_op("t1", WP'(3), WP'(5), 256, WO'(15));
`endif
        @(negedge clk);
        chk("t1_done_pulse", WO'(done), '0);

        run_op("max", ones, ones, done_edge(ones), max_sq);
        chk("max_top_bits", WO'(product[511:510]), '0);

        // back-to-back: start at the negedge where done is high
        run_op("prime", PRIME, WP'(1), done_edge(WP'(1)), WO'(PRIME));
        run_op("zero_a", '0, WP'(12345), done_edge(WP'(12345)), '0);
        @(negedge clk);
        chk("b2b_done_pulse", WO'(done), '0);

        // start with new operands mid-operation is ignored
        start = 1'b1;
        A = WP'(11);
        B = ones;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        start = 1'b1;
        A = WP'(999);
        B = WP'(3);
        @(negedge clk);
        start = 1'b0;
        n = 100;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("ignore_lat", WO'(n), WO'(256));
        chk("ignore_prod", product, WO'(11) * WO'(ones));

        // reset mid-operation, with start asserted alongside it
        @(negedge clk);
        start = 1'b1;
        A = WP'(5);
        B = WP'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("abort_done", WO'(done), '0);
        chk("abort_busy", WO'(busy), '0);
        chk("abort_prod", product, '0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", WO'(busy), '0);
        run_op("after_rst", WP'(7), WP'(9), done_edge(WP'(9)), WO'(63));

`ifdef EARLY_EXIT_EN
        run_op("ee_b0", WP'(77), '0, 2, '0);
        run_op("ee_b1", WP'(77), WP'(1), 2, WO'(77));
        run_op("ee_b254", WP'(3), p254, 256, WO'(3) << 254);
`else
        run_op("ee_b0", WP'(77), '0, 256, '0);
        run_op("ee_b1", WP'(77), WP'(1), 256, WO'(77));
        run_op("ee_b254", WP'(3), p254, 256, WO'(3) << 254);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
